// File: rtl/host_link_router.sv
// host_link_router: host-side endpoint of the channel message bus.
// RX decodes SYNC/ADDR/LEN/payload frames from the host into one-hot channel
// strobes; TX round-robins over pending channels, reads their bytes and frames
// them onto a valid/ready byte stream toward the host transmitter.
module host_link_router #(
  parameter int unsigned N_CH        = 5,
  parameter logic [7:0]  SYNC        = 8'hAA,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                n_rst,
  input  logic                sys_clk,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [7:0]          master_data,
  output logic [N_CH-1:0]     valid_bus,
  input  logic [N_CH-1:0]     have_msg_bus,
  input  logic [8*N_CH-1:0]   len_bus,
  input  logic [8*N_CH-1:0]   slave_data_bus,
  output logic [N_CH-1:0]     rdreq_bus,
  output logic [7:0]          err_cnt
);

  localparam int unsigned PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    RX_HUNT,
    RX_ADDR,
    RX_LEN,
    RX_PAYLOAD
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_SCAN,
    TX_H_SYNC,
    TX_H_ADDR,
    TX_H_LEN,
    TX_RD,
    TX_WAIT,
    TX_SEND
  } tx_state_t;

  // ---------------------------------------------------------------- RX path
  rx_state_t         rx_state_q, rx_state_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        rx_cnt_q, rx_cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [7:0]        master_data_q, master_data_d;
  logic [N_CH-1:0]   valid_bus_q, valid_bus_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              err_inc;

  // RX state and output registers
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_state_q    <= RX_HUNT;
      addr_q        <= 8'd0;
      rx_cnt_q      <= 8'd0;
      tmo_q         <= '0;
      master_data_q <= 8'd0;
      valid_bus_q   <= '0;
      err_cnt_q     <= 8'd0;
    end else begin
      rx_state_q    <= rx_state_d;
      addr_q        <= addr_d;
      rx_cnt_q      <= rx_cnt_d;
      tmo_q         <= tmo_d;
      master_data_q <= master_data_d;
      valid_bus_q   <= valid_bus_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  // RX frame decoder, inactivity watchdog and error counter
  always_comb begin
    rx_state_d    = rx_state_q;
    addr_d        = addr_q;
    rx_cnt_d      = rx_cnt_q;
    tmo_d         = tmo_q;
    master_data_d = master_data_q;
    valid_bus_d   = '0;
    err_cnt_d     = err_cnt_q;
    err_inc       = 1'b0;

    case (rx_state_q)
      RX_HUNT: begin
        if (rx_valid && (rx_data == SYNC)) begin
          rx_state_d = RX_ADDR;
        end
      end
      RX_ADDR: begin
        if (rx_valid) begin
          addr_d     = rx_data;
          rx_state_d = RX_LEN;
          // A bad address is charged once, when the frame is addressed
          if (rx_data >= 8'(N_CH)) begin
            err_inc = 1'b1;
          end
        end
      end
      RX_LEN: begin
        if (rx_valid) begin
          rx_cnt_d   = rx_data;
          rx_state_d = (rx_data == 8'd0) ? RX_HUNT : RX_PAYLOAD;
        end
      end
      RX_PAYLOAD: begin
        if (rx_valid) begin
          // Out-of-range addresses match no channel, so the byte is dropped
          for (int unsigned k = 0; k < N_CH; k++) begin
            valid_bus_d[k] = (addr_q == 8'(k));
          end
          if (addr_q < 8'(N_CH)) begin
            master_data_d = rx_data;
          end
          rx_cnt_d = rx_cnt_q - 8'd1;
          if (rx_cnt_q == 8'd1) begin
            rx_state_d = RX_HUNT;
          end
        end
      end
      default: rx_state_d = RX_HUNT;
    endcase

    // Watchdog only runs while a frame is open
    if (rx_state_q == RX_HUNT) begin
      tmo_d = '0;
    end else if (rx_valid) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
      tmo_d      = '0;
      rx_state_d = RX_HUNT;
      err_inc    = 1'b1;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------- TX path
  tx_state_t         tx_state_q, tx_state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  sel_q, sel_d;
  logic [7:0]        tx_cnt_q, tx_cnt_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic [N_CH-1:0]   rdreq_q, rdreq_d;

  logic              cur_have;
  logic [7:0]        cur_len;
  logic [7:0]        sel_data;
  logic [N_CH-1:0]   sel_onehot;
  logic [PTR_W-1:0]  ptr_next;
  logic [PTR_W-1:0]  sel_next;
  logic              accept;

  // TX state and output registers
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_state_q <= TX_SCAN;
      ptr_q      <= '0;
      sel_q      <= '0;
      tx_cnt_q   <= 8'd0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      rdreq_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rdreq_q    <= rdreq_d;
    end
  end

  // Channel muxes: candidate under the scan pointer, and the selected channel
  always_comb begin
    cur_have   = 1'b0;
    cur_len    = 8'd0;
    sel_data   = 8'd0;
    sel_onehot = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (ptr_q == PTR_W'(k)) begin
        cur_have = have_msg_bus[k];
        cur_len  = len_bus[8*k +: 8];
      end
      if (sel_q == PTR_W'(k)) begin
        sel_data      = slave_data_bus[8*k +: 8];
        sel_onehot[k] = 1'b1;
      end
    end
    ptr_next = (ptr_q == PTR_W'(N_CH - 1)) ? '0 : ptr_q + PTR_W'(1);
    sel_next = (sel_q == PTR_W'(N_CH - 1)) ? '0 : sel_q + PTR_W'(1);
  end

  // TX scheduler and framer
  always_comb begin
    tx_state_d = tx_state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    tx_cnt_d   = tx_cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    rdreq_d    = '0;
    accept     = tx_valid_q & tx_ready;

    case (tx_state_q)
      TX_SCAN: begin
        if (cur_have && (cur_len != 8'd0)) begin
          sel_d      = ptr_q;
          tx_cnt_d   = cur_len;
          tx_data_d  = SYNC;
          tx_valid_d = 1'b1;
          tx_state_d = TX_H_SYNC;
        end else begin
          ptr_d = ptr_next;
        end
      end
      TX_H_SYNC: begin
        if (accept) begin
          tx_data_d  = 8'(sel_q);
          tx_state_d = TX_H_ADDR;
        end
      end
      TX_H_ADDR: begin
        if (accept) begin
          tx_data_d  = tx_cnt_q;
          tx_state_d = TX_H_LEN;
        end
      end
      TX_H_LEN: begin
        if (accept) begin
          tx_valid_d = 1'b0;
          rdreq_d    = sel_onehot;
          tx_state_d = TX_RD;
        end
      end
      TX_RD: begin
        tx_state_d = TX_WAIT;
      end
      TX_WAIT: begin
        // Read data is valid here, one cycle after the rdreq pulse
        tx_data_d  = sel_data;
        tx_valid_d = 1'b1;
        tx_state_d = TX_SEND;
      end
      TX_SEND: begin
        if (accept) begin
          tx_valid_d = 1'b0;
          tx_cnt_d   = tx_cnt_q - 8'd1;
          if (tx_cnt_q == 8'd1) begin
            ptr_d      = sel_next;
            tx_state_d = TX_SCAN;
          end else begin
            rdreq_d    = sel_onehot;
            tx_state_d = TX_RD;
          end
        end
      end
      default: tx_state_d = TX_SCAN;
    endcase
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign rdreq_bus   = rdreq_q;
  assign master_data = master_data_q;
  assign valid_bus   = valid_bus_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_host_link_router.sv
// Directed bench for host_link_router: RX decode, errors, timeout, reset,
// TX framing, backpressure, round-robin and concurrent RX/TX traffic.
module tb_host_link_router;

  localparam int unsigned N_CH = 5;
  localparam int unsigned TMO  = 40;

  logic                n_rst;
  logic                sys_clk;
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic [7:0]          master_data;
  logic [N_CH-1:0]     valid_bus;
  logic [N_CH-1:0]     have_msg_bus;
  logic [8*N_CH-1:0]   len_bus;
  logic [8*N_CH-1:0]   slave_data_bus = '0;
  logic [N_CH-1:0]     rdreq_bus;
  logic [7:0]          err_cnt;

  host_link_router #(.N_CH(N_CH), .SYNC(8'hAA), .TIMEOUT_CYC(TMO)) dut (
    .n_rst(n_rst), .sys_clk(sys_clk),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .master_data(master_data), .valid_bus(valid_bus),
    .have_msg_bus(have_msg_bus), .len_bus(len_bus),
    .slave_data_bus(slave_data_bus), .rdreq_bus(rdreq_bus),
    .err_cnt(err_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_err;

  // Channel model: per-channel byte store, read one byte per rdreq
  logic [7:0] ch_mem [N_CH][64];
  int         ch_wr  [N_CH] = '{default: 0};
  int         ch_rd  [N_CH] = '{default: 0};
  logic [7:0] msg_len [N_CH] = '{default: 8'd0};

  always_comb begin
    have_msg_bus = '0;
    len_bus      = '0;
    for (int k = 0; k < N_CH; k++) begin
      have_msg_bus[k]   = (ch_rd[k] < ch_wr[k]);
      len_bus[8*k +: 8] = (ch_rd[k] < ch_wr[k]) ? msg_len[k] : 8'd0;
    end
  end

  always @(posedge sys_clk) begin
    for (int k = 0; k < N_CH; k++) begin
      if (rdreq_bus[k]) begin
        slave_data_bus[8*k +: 8] <= ch_mem[k][6'(ch_rd[k])];
        ch_rd[k] <= ch_rd[k] + 1;
      end
    end
  end

  // Monitor on the falling edge, away from DUT updates
  int              cyc = 0;
  int              rx_cyc [$];
  logic [N_CH-1:0] stb_bus [$];
  logic [7:0]      stb_data [$];
  int              stb_cyc [$];
  logic [7:0]      tx_log [$];
  int              rdreq_cnt [N_CH] = '{default: 0};
  int              viol_multihot = 0;
  int              viol_hold = 0;
  int              viol_rd_busy = 0;
  logic            prev_stall = 1'b0;
  logic [7:0]      prev_data = 8'd0;

  always @(negedge sys_clk) begin
    cyc <= cyc + 1;
    if (n_rst) begin
      if (rx_valid) rx_cyc.push_back(cyc);
      if (valid_bus != '0) begin
        stb_bus.push_back(valid_bus);
        stb_data.push_back(master_data);
        stb_cyc.push_back(cyc);
      end
      if ($countones(valid_bus) > 1 || $countones(rdreq_bus) > 1) viol_multihot <= viol_multihot + 1;
      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
      for (int k = 0; k < N_CH; k++) begin
        if (rdreq_bus[k]) rdreq_cnt[k] <= rdreq_cnt[k] + 1;
      end
      if (rdreq_bus != '0 && tx_valid) viol_rd_busy <= viol_rd_busy + 1;
      if (prev_stall && (!tx_valid || tx_data != prev_data)) viol_hold <= viol_hold + 1;
      prev_stall <= tx_valid && !tx_ready;
      prev_data  <= tx_data;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(1);
  endtask

  task automatic load_ch(input int k, input logic [7:0] len, input int n,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] bs [3];
    bs[0] = b0; bs[1] = b1; bs[2] = b2;
    for (int i = 0; i < n; i++) ch_mem[k][6'(ch_wr[k] + i)] = bs[i];
    msg_len[k] = len;
    ch_wr[k]   = ch_wr[k] + n;
  endtask

  task automatic wait_tx(input int target, input string name);
    for (int i = 0; i < 400; i++) begin
      if (tx_log.size() >= target) break;
      tick(1);
    end
    n_vec++;
    if (tx_log.size() < target) begin
      n_err++;
      $display("FAIL %s tx byte count: got %0d want %0d", name, tx_log.size(), target);
    end
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    tick(3);
    n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rst tx_data: got %h want 00", tx_data); end
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rst tx_valid: got %b want 0", tx_valid); end
    n_vec++; if (master_data !== 8'h00) begin n_err++; $display("FAIL rst master_data: got %h want 00", master_data); end
    n_vec++; if (valid_bus !== 5'b0) begin n_err++; $display("FAIL rst valid_bus: got %b want 00000", valid_bus); end
    n_vec++; if (rdreq_bus !== 5'b0) begin n_err++; $display("FAIL rst rdreq_bus: got %b want 00000", rdreq_bus); end
    n_vec++; if (err_cnt !== 8'h00) begin n_err++; $display("FAIL rst err_cnt: got %h want 00", err_cnt); end
    n_rst = 1'b1;
    tick(4);
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL idle tx_valid: got %b want 0", tx_valid); end
    exp_err = 8'd0;
  endtask

  task automatic test_rx_basic;
    int s0 = stb_bus.size();
    int r0 = rx_cyc.size();
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h02); send_byte(8'h5A); send_byte(8'hC3);
    tick(2);
    n_vec++; if (stb_bus.size() !== s0 + 2) begin n_err++; $display("FAIL rx_basic strobes: got %0d want 2", stb_bus.size() - s0); end
    n_vec++; if (stb_bus[s0] !== 5'b01000) begin n_err++; $display("FAIL rx_basic bus0: got %b want 01000", stb_bus[s0]); end
    n_vec++; if (stb_data[s0] !== 8'h5A) begin n_err++; $display("FAIL rx_basic data0: got %h want 5a", stb_data[s0]); end
    n_vec++; if (stb_cyc[s0] !== rx_cyc[r0+3] + 1) begin n_err++; $display("FAIL rx_basic lat0: got %0d want %0d", stb_cyc[s0], rx_cyc[r0+3] + 1); end
    n_vec++; if (stb_bus[s0+1] !== 5'b01000) begin n_err++; $display("FAIL rx_basic bus1: got %b want 01000", stb_bus[s0+1]); end
    n_vec++; if (stb_data[s0+1] !== 8'hC3) begin n_err++; $display("FAIL rx_basic data1: got %h want c3", stb_data[s0+1]); end
    n_vec++; if (stb_cyc[s0+1] !== rx_cyc[r0+4] + 1) begin n_err++; $display("FAIL rx_basic lat1: got %0d want %0d", stb_cyc[s0+1], rx_cyc[r0+4] + 1); end
    n_vec++; if (master_data !== 8'hC3) begin n_err++; $display("FAIL rx_basic hold: got %h want c3", master_data); end
  endtask

  task automatic test_rx_bad_addr;
    int s0 = stb_bus.size();
    send_byte(8'hAA); send_byte(8'h07); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
    tick(2);
    exp_err = exp_err + 8'd1;
    n_vec++; if (stb_bus.size() !== s0) begin n_err++; $display("FAIL bad_addr strobes: got %0d want 0", stb_bus.size() - s0); end
    n_vec++; if (err_cnt !== exp_err) begin n_err++; $display("FAIL bad_addr err_cnt: got %h want %h", err_cnt, exp_err); end
    n_vec++; if (master_data !== 8'hC3) begin n_err++; $display("FAIL bad_addr master_data: got %h want c3", master_data); end
    send_byte(8'hAA); send_byte(8'h00); send_byte(8'h01); send_byte(8'h01);
    tick(2);
    n_vec++; if (stb_bus.size() !== s0 + 1) begin n_err++; $display("FAIL good_after_bad strobes: got %0d want 1", stb_bus.size() - s0); end
    n_vec++; if (stb_bus[s0] !== 5'b00001) begin n_err++; $display("FAIL good_after_bad bus: got %b want 00001", stb_bus[s0]); end
    n_vec++; if (stb_data[s0] !== 8'h01) begin n_err++; $display("FAIL good_after_bad data: got %h want 01", stb_data[s0]); end
  endtask

  task automatic test_rx_len0;
    int s0 = stb_bus.size();
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h01); send_byte(8'h77);
    tick(2);
    n_vec++; if (stb_bus.size() !== s0 + 1) begin n_err++; $display("FAIL len0 strobes: got %0d want 1", stb_bus.size() - s0); end
    n_vec++; if (stb_bus[s0] !== 5'b00100) begin n_err++; $display("FAIL len0 bus: got %b want 00100", stb_bus[s0]); end
    n_vec++; if (stb_data[s0] !== 8'h77) begin n_err++; $display("FAIL len0 data: got %h want 77", stb_data[s0]); end
  endtask

  task automatic test_rx_timeout;
    int s0 = stb_bus.size();
    send_byte(8'hAA); send_byte(8'h01);
    tick(TMO / 2);
    n_vec++; if (err_cnt !== exp_err) begin n_err++; $display("FAIL tmo early err_cnt: got %h want %h", err_cnt, exp_err); end
    tick(TMO);
    exp_err = exp_err + 8'd1;
    n_vec++; if (err_cnt !== exp_err) begin n_err++; $display("FAIL tmo err_cnt: got %h want %h", err_cnt, exp_err); end
    send_byte(8'h55);
    tick(2);
    n_vec++; if (stb_bus.size() !== s0) begin n_err++; $display("FAIL tmo 55 strobes: got %0d want 0", stb_bus.size() - s0); end
    send_byte(8'hAA); send_byte(8'h01);
    tick(TMO - 10);
    send_byte(8'h01);
    tick(TMO - 10);
    send_byte(8'h9C);
    tick(2);
    n_vec++; if (stb_bus.size() !== s0 + 1) begin n_err++; $display("FAIL tmo slow strobes: got %0d want 1", stb_bus.size() - s0); end
    n_vec++; if (stb_bus[s0] !== 5'b00010) begin n_err++; $display("FAIL tmo slow bus: got %b want 00010", stb_bus[s0]); end
    n_vec++; if (stb_data[s0] !== 8'h9C) begin n_err++; $display("FAIL tmo slow data: got %h want 9c", stb_data[s0]); end
    n_vec++; if (err_cnt !== exp_err) begin n_err++; $display("FAIL tmo slow err_cnt: got %h want %h", err_cnt, exp_err); end
  endtask

  task automatic test_reset_midframe;
    int s0 = stb_bus.size();
    send_byte(8'hAA); send_byte(8'h00); send_byte(8'h03); send_byte(8'h01);
    n_rst = 1'b0;
    tick(2);
    n_vec++; if (master_data !== 8'h00) begin n_err++; $display("FAIL midrst master_data: got %h want 00", master_data); end
    n_rst = 1'b1;
    tick(1);
    send_byte(8'h02); send_byte(8'h03);
    tick(2);
    exp_err = 8'd0;
    n_vec++; if (stb_bus.size() !== s0 + 1) begin n_err++; $display("FAIL midrst strobes: got %0d want 1", stb_bus.size() - s0); end
    n_vec++; if (err_cnt !== exp_err) begin n_err++; $display("FAIL midrst err_cnt: got %h want %h", err_cnt, exp_err); end
  endtask

  task automatic test_tx_basic;
    int b0 = tx_log.size();
    int r4 = rdreq_cnt[4];
    logic [7:0] exp [6] = '{8'hAA, 8'h04, 8'h03, 8'h10, 8'h20, 8'h30};
    tx_ready = 1'b1;
    load_ch(4, 8'd3, 3, 8'h10, 8'h20, 8'h30);
    wait_tx(b0 + 6, "tx_basic");
    for (int i = 0; i < 6; i++) begin
      n_vec++; if (tx_log[b0+i] !== exp[i]) begin n_err++; $display("FAIL tx_basic byte%0d: got %h want %h", i, tx_log[b0+i], exp[i]); end
    end
    tick(10);
    n_vec++; if (rdreq_cnt[4] - r4 !== 3) begin n_err++; $display("FAIL tx_basic rdreq: got %0d want 3", rdreq_cnt[4] - r4); end
    n_vec++; if (tx_log.size() !== b0 + 6) begin n_err++; $display("FAIL tx_basic extra: got %0d want 6", tx_log.size() - b0); end
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_basic idle valid: got %b want 0", tx_valid); end
  endtask

  task automatic test_tx_backpressure;
    int b0 = tx_log.size();
    int r4 = rdreq_cnt[4];
    logic [7:0] exp [6] = '{8'hAA, 8'h04, 8'h03, 8'h10, 8'h20, 8'h30};
    tx_ready = 1'b1;
    load_ch(4, 8'd3, 3, 8'h10, 8'h20, 8'h30);
    for (int i = 0; i < 200; i++) begin
      if (tx_valid === 1'b1 && tx_data === 8'h20) break;
      tick(1);
    end
    tx_ready = 1'b0;
    tick(5);
    n_vec++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL bp valid: got %b want 1", tx_valid); end
    n_vec++; if (tx_data !== 8'h20) begin n_err++; $display("FAIL bp data: got %h want 20", tx_data); end
    n_vec++; if (rdreq_cnt[4] - r4 !== 2) begin n_err++; $display("FAIL bp rdreq stalled: got %0d want 2", rdreq_cnt[4] - r4); end
    tx_ready = 1'b1;
    wait_tx(b0 + 6, "bp");
    for (int i = 0; i < 6; i++) begin
      n_vec++; if (tx_log[b0+i] !== exp[i]) begin n_err++; $display("FAIL bp byte%0d: got %h want %h", i, tx_log[b0+i], exp[i]); end
    end
    tick(10);
    n_vec++; if (rdreq_cnt[4] - r4 !== 3) begin n_err++; $display("FAIL bp rdreq: got %0d want 3", rdreq_cnt[4] - r4); end
  endtask

  task automatic test_round_robin;
    int b0 = tx_log.size();
    int r1 = rdreq_cnt[1];
    int r4 = rdreq_cnt[4];
    logic [7:0] exp [12] = '{8'hAA, 8'h01, 8'h01, 8'h11,
                             8'hAA, 8'h04, 8'h01, 8'h44,
                             8'hAA, 8'h01, 8'h01, 8'h12};
    load_ch(1, 8'd1, 2, 8'h11, 8'h12, 8'h00);
    load_ch(4, 8'd1, 1, 8'h44, 8'h00, 8'h00);
    wait_tx(b0 + 12, "rr");
    for (int i = 0; i < 12; i++) begin
      n_vec++; if (tx_log[b0+i] !== exp[i]) begin n_err++; $display("FAIL rr byte%0d: got %h want %h", i, tx_log[b0+i], exp[i]); end
    end
    tick(10);
    n_vec++; if (rdreq_cnt[1] - r1 !== 2) begin n_err++; $display("FAIL rr rdreq1: got %0d want 2", rdreq_cnt[1] - r1); end
    n_vec++; if (rdreq_cnt[4] - r4 !== 1) begin n_err++; $display("FAIL rr rdreq4: got %0d want 1", rdreq_cnt[4] - r4); end
  endtask

  task automatic test_concurrent;
    int b0 = tx_log.size();
    int s0 = stb_bus.size();
    logic [7:0] exp [4] = '{8'hAA, 8'h02, 8'h01, 8'h5E};
    load_ch(2, 8'd1, 1, 8'h5E, 8'h00, 8'h00);
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h01); send_byte(8'h66);
    tick(2);
    n_vec++; if (stb_bus.size() !== s0 + 1) begin n_err++; $display("FAIL conc strobes: got %0d want 1", stb_bus.size() - s0); end
    n_vec++; if (stb_data[s0] !== 8'h66) begin n_err++; $display("FAIL conc data: got %h want 66", stb_data[s0]); end
    wait_tx(b0 + 4, "conc");
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (tx_log[b0+i] !== exp[i]) begin n_err++; $display("FAIL conc byte%0d: got %h want %h", i, tx_log[b0+i], exp[i]); end
    end
  endtask

  task automatic test_err_saturate;
    for (int i = 0; i < 260; i++) begin
      send_byte(8'hAA); send_byte(8'h07); send_byte(8'h00);
    end
    tick(2);
    n_vec++; if (err_cnt !== 8'hFF) begin n_err++; $display("FAIL err_sat: got %h want ff", err_cnt); end
  endtask

  task automatic test_protocol;
    n_vec++; if (viol_multihot !== 0) begin n_err++; $display("FAIL multihot events: got %0d want 0", viol_multihot); end
    n_vec++; if (viol_hold !== 0) begin n_err++; $display("FAIL hold events: got %0d want 0", viol_hold); end
    n_vec++; if (viol_rd_busy !== 0) begin n_err++; $display("FAIL rdreq_busy events: got %0d want 0", viol_rd_busy); end
  endtask

  initial begin
    n_rst    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    exp_err  = 8'd0;
    test_reset;
    test_rx_basic;
    test_rx_bad_addr;
    test_rx_len0;
    test_rx_timeout;
    test_reset_midframe;
    test_tx_basic;
    test_tx_backpressure;
    test_round_robin;
    test_concurrent;
    test_err_saturate;
    test_protocol;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/host_link_router.md
Name: host_link_router

Overview:
- Host-side endpoint of the channel message bus used by the functional-test blocks.
- RX path: decodes framed byte packets from the host serial receiver and drives master_data with one-hot valid_bus strobes, one strobe per payload byte.
- TX path: scans each channel's have_msg_bus flag and reads that channel's pending bytes with rdreq_bus pulses. It frames the bytes and streams them to the host serial transmitter over a valid/ready handshake.
- Sits between the UART/FTDI byte layer and the channel blocks (control, HD/VD, black level, start/stop, video samples).

Parameters:
- N_CH, 5, number of channels; width of valid_bus, rdreq_bus and have_msg_bus.
- SYNC, 8'hAA, frame sync byte, used in both directions.
- TIMEOUT_CYC, 100000, sys_clk cycles of RX inactivity inside a frame before the frame is aborted.

Ports:
- n_rst  in  1  reset, asynchronous, active-low
- sys_clk  in  1  clock; all logic runs in this domain
- rx_data  in  8  byte from host receiver
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to host transmitter
- tx_valid  out  1  tx_data valid; held until accepted
- tx_ready  in  1  transmitter accepts byte when tx_valid & tx_ready
- master_data  out  8  payload byte to channels
- valid_bus  out  N_CH  one-hot payload strobe, bit = channel address
- have_msg_bus  in  N_CH  channel has bytes to send
- len_bus  in  8*N_CH  pending byte count per channel; channel k at [8k+7:8k]
- slave_data_bus  in  8*N_CH  read data per channel, same slicing; valid 1 cycle after rdreq
- rdreq_bus  out  N_CH  one-cycle read pulse, one-hot
- err_cnt  out  8  count of RX frames with bad address or timeout, saturating

Behaviour:
- Reset values: tx_data=0, tx_valid=0, master_data=0, valid_bus=0, rdreq_bus=0, err_cnt=0. Both FSMs go to their first state and the round-robin pointer is 0.
- Reset mid-frame aborts both paths immediately, with no partial strobes after release.
- Frame format, both directions: SYNC, ADDR, LEN, then LEN payload bytes. LEN ranges 0..255.
- RX FSM: HUNT -> ADDR -> LEN -> PAYLOAD -> HUNT.
  - HUNT: a byte other than SYNC is ignored.
  - ADDR and LEN bytes are latched.
  - LEN=0: go to HUNT with no strobes.
  - PAYLOAD: on each rx_valid, on the next cycle master_data <= rx_data and valid_bus[ADDR] pulses for exactly 1 cycle (latency 1). Decrement the count; at 0, go to HUNT.
  - ADDR >= N_CH: payload bytes are consumed without any strobe, and err_cnt increments once per such frame.
- RX timeout: an inactivity counter resets on every rx_valid while not in HUNT. Reaching TIMEOUT_CYC sends the FSM to HUNT and increments err_cnt.
- err_cnt saturates at 255.
- valid_bus is never multi-hot. master_data holds its last value between strobes.
- TX FSM: SCAN -> H_SYNC -> H_ADDR -> H_LEN -> RD -> WAIT -> SEND -> (RD or SCAN).
  - SCAN: search one channel per cycle, starting at the pointer. A channel is selected if have_msg_bus[k]=1 and len_bus[k]!=0; latch k and cnt=len_bus[k].
  - If the checked channel does not qualify, advance the pointer modulo N_CH.
  - H_SYNC, H_ADDR and H_LEN present SYNC, k and cnt in turn. Each byte holds until tx_ready.
  - RD: rdreq_bus[k]=1 for 1 cycle.
  - WAIT: 1 idle cycle.
  - SEND: tx_data <= slave_data_bus[k] (captured in the cycle after rdreq), tx_valid=1. Hold until tx_valid & tx_ready; tx_valid drops the cycle after acceptance. Decrement cnt; cnt!=0 -> RD, else pointer=k+1 mod N_CH and -> SCAN.
- Handshake rules:
  - tx_data must be stable while tx_valid=1 and tx_ready=0.
  - No rdreq pulse is issued while a data byte is unaccepted.
  - At most one rdreq per data byte, giving exactly cnt pulses per frame.
- The latched cnt is used even if have_msg_bus[k] or len_bus[k] changes mid-frame. have_msg_bus is sampled only in SCAN.
- RX and TX are independent: both may be active in the same cycle, and neither stalls the other.

Test Plan:
- RX: bytes AA,03,02,5A,C3 -> two 1-cycle valid_bus=5'b01000 strobes with master_data 5A then C3, each 1 cycle after its rx_valid.
- RX: bytes AA,07,02,11,22 -> valid_bus stays 0 and err_cnt=1. A following AA,00,01,01 gives one valid_bus=5'b00001 strobe with master_data=01.
- RX timeout: AA,01 then silence for TIMEOUT_CYC cycles -> err_cnt+1 and FSM in HUNT. A following 55 produces no strobe.
- TX: have_msg_bus[4]=1, len=3, slave data 10,20,30, tx_ready=1 -> tx bytes AA,04,03,10,20,30. Exactly 3 rdreq_bus[4] pulses, then SCAN.
- TX backpressure: tx_ready low for 5 cycles during byte 2 -> tx_data held at 20, no extra rdreq, correct final sequence.
- Round-robin: channels 1 and 4 both pending with len=1 -> frame for 1, then frame for 4. Channel 1 re-asserted is then served after 4, before 1 is served again.
